msx_ppi: RTL
============

Name: msx_ppi

Overview:
- Cycle-accurate subset of the i8255 PPI for the MSX1 core, placed downstream of the I/O decoder (enabled by `ppi_n`, I/O ports A8h–ABh).
- Holds the primary-slot register (port A) and returns keyboard column data (port B).
- Drives keyboard row select, cassette, caps LED and key click (port C).
- Provides a combinational primary-slot lookup for the current CPU memory page, used by the memory mapper.

Parameters:
- `RESET_CTRL`, default 8'h82, control word loaded at reset (A out, B in, C out, mode 0).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `ppi_n`  in  1  chip select from I/O decoder, active low
- `rd_n`  in  1  CPU read strobe, active low
- `wr_n`  in  1  CPU write strobe, active low
- `addr`  in  2  CPU A[1:0]: 0=A, 1=B, 2=C, 3=control
- `d_i`  in  8  CPU write data
- `d_o`  out  8  read data, registered
- `page`  in  2  CPU A[15:14]
- `mem_slot`  out  2  primary slot for `page`, combinational
- `kb_col_i`  in  8  keyboard column bits, active low
- `kb_row_o`  out  4  keyboard row select (port C[3:0])
- `cas_motor_n_o`  out  1  port C[4]
- `cas_out_o`  out  1  port C[5]
- `caps_led_o`  out  1  port C[6]
- `key_click_o`  out  1  port C[7]

Behaviour:
- Reset (synchronous, active high):
  - `ctrl` = `RESET_CTRL`; `pa`, `pb`, `pc` latches = 0.
  - `d_o` = 8'hFF; write-edge register `wr_q` = 0.
  - All port-derived outputs are 0, so `mem_slot` = 0 for every page.
- Write detect:
  - `wr_act` = ~`ppi_n` & ~`wr_n`.
  - Register `wr_q` <= `wr_act` every clk.
  - A write commits exactly once, on the clk where `wr_act`=1 and `wr_q`=0. Holding the strobe for many cycles (T80 wait/CEN) does not re-commit.
- Write decode on commit:
  - `addr`=0: `pa` <= `d_i`.
  - `addr`=1: `pb` <= `d_i` (latched; only visible when B is configured as output).
  - `addr`=2: `pc` <= `d_i`.
  - `addr`=3 with `d_i[7]`=1 (mode set):
    - `ctrl` <= `d_i`.
    - `pa`, `pb`, `pc` cleared to 0, per 8255.
    - Mode bits [6:5] and [2] are stored but ignored; only mode 0 is implemented.
  - `addr`=3 with `d_i[7]`=0 (bit set/reset): `pc[d_i[3:1]]` <= `d_i[0]`; other `pc` bits and `ctrl` unchanged.
- Direction, taken from `ctrl`:
  - A is input when `ctrl[4]`.
  - B is input when `ctrl[1]`.
  - C upper nibble is input when `ctrl[3]`.
  - C lower nibble is input when `ctrl[0]`.
  - An input-configured output port drives all-ones on its pins (pull-up model); the internal latch is retained.
- Effective pins:
  - `pa_pin` = `ctrl[4]` ? FF : `pa`.
  - `pc_pin` = {`ctrl[3]` ? F : `pc[7:4]`, `ctrl[0]` ? F : `pc[3:0]`}.
  - `kb_row_o` = `pc_pin[3:0]`; `cas_motor_n_o` = `pc_pin[4]`; `cas_out_o` = `pc_pin[5]`; `caps_led_o` = `pc_pin[6]`; `key_click_o` = `pc_pin[7]`.
- `mem_slot` = `pa_pin[2*page+1 : 2*page]`.
  - page 0 → bits[1:0], page 3 → bits[7:6].
  - Purely combinational, no latency.
- Read:
  - `d_o` updated every clk (1-cycle latency), independent of `rd_n`.
  - `addr`=0 → `pa_pin`.
  - `addr`=1 → `ctrl[1]` ? `kb_col_i` : `pb`.
  - `addr`=2 → `pc_pin`.
  - `addr`=3 → 8'hFF.
  - When `ppi_n`=1, `d_o` = 8'hFF.
  - A read has no side effects.
- Simultaneous read and write (both strobes low): the write commits; `d_o` shows the post-write value one clk later.
- Reset asserted mid-strobe: `wr_q` clears. If `wr_act` is still 1 when reset deasserts, that write commits on the first clk after reset. This is accepted; the CPU is also in reset, so it cannot occur in system use.

Test Plan:
- Reset, then read `addr`0 → `d_o`=00; `mem_slot`=0 for `page` 0..3; `kb_row_o`=0; `key_click_o`=0.
- Write A=8'hE4 with `wr_n` held low 20 clk → single commit (assert one `pa` update); `page` 0,1,2,3 → `mem_slot` 0,1,2,3.
- `kb_col_i`=8'hFB, write C=8'h05, read B → `d_o`=FB on the next clk; `kb_row_o`=5.
- Bit set/reset: write ctrl 8'h0F → `key_click_o`=1, `pc` low nibble unchanged; then write 8'h0E → `key_click_o`=0.
- Mode write 8'h92 after A=FF, C=AA → `pa`, `pc` cleared; A now input so `pa_pin`=FF and `mem_slot`=3; read A=FF, read C=00.
- `ppi_n`=1 with `wr_n`=0, `addr`0, `d_i`=55 → no change to `pa`; `d_o`=FF.

Source files
------------

// File: rtl/msx_ppi.sv
// msx_ppi: mode-0 subset of the i8255 PPI used by the MSX1 core.
// Port A holds the primary-slot register, port B reads keyboard columns,
// port C drives keyboard row select, cassette, caps LED and key click.
//
// Write strobe semantics: a write is active while ppi_n and wr_n are both
// low. It commits exactly once, on the first clk where it is active and was
// not active on the previous clk, so a strobe stretched by CPU wait states
// never commits twice. Reads are side-effect free; d_o is refreshed every
// clk from the currently addressed port, regardless of rd_n.
module msx_ppi #(
  parameter logic [7:0] RESET_CTRL = 8'h82
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ppi_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] d_i,
  output logic [7:0] d_o,
  input  logic [1:0] page,
  output logic [1:0] mem_slot,
  input  logic [7:0] kb_col_i,
  output logic [3:0] kb_row_o,
  output logic       cas_motor_n_o,
  output logic       cas_out_o,
  output logic       caps_led_o,
  output logic       key_click_o
);

  // Only the four direction bits of the control word affect behaviour in
  // mode 0, so only those are kept: {A in, C upper in, B in, C lower in}.
  localparam logic [3:0] RESET_DIR = {RESET_CTRL[4], RESET_CTRL[3],
                                      RESET_CTRL[1], RESET_CTRL[0]};

  logic [3:0] dir_q, dir_d;
  logic [7:0] pa_q, pa_d;
  logic [7:0] pb_q, pb_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] d_o_q, d_o_d;
  logic       wr_q, wr_d;

  logic       wr_act;
  logic       commit;
  logic       a_in, cu_in, b_in, cl_in;
  logic [7:0] pa_pin;
  logic [7:0] pc_pin;

  assign a_in  = dir_q[3];
  assign cu_in = dir_q[2];
  assign b_in  = dir_q[1];
  assign cl_in = dir_q[0];

  assign wr_act = ~ppi_n & ~wr_n;
  assign commit = wr_act & ~wr_q;

  // Pin view of the ports: input-configured ports read as pulled-up ones.
  always_comb begin
    pa_pin = a_in ? 8'hFF : pa_q;
    pc_pin = {cu_in ? 4'hF : pc_q[7:4], cl_in ? 4'hF : pc_q[3:0]};
  end

  assign kb_row_o      = pc_pin[3:0];
  assign cas_motor_n_o = pc_pin[4];
  assign cas_out_o     = pc_pin[5];
  assign caps_led_o    = pc_pin[6];
  assign key_click_o   = pc_pin[7];

  // Primary slot for the current CPU page, straight from the port A pins.
  always_comb begin
    mem_slot = pa_pin[1:0];
    case (page)
      2'd0: mem_slot = pa_pin[1:0];
      2'd1: mem_slot = pa_pin[3:2];
      2'd2: mem_slot = pa_pin[5:4];
      2'd3: mem_slot = pa_pin[7:6];
      default: mem_slot = pa_pin[1:0];
    endcase
  end

  // Register write decode on the committing clk and read-data selection.
  always_comb begin
    dir_d = dir_q;
    pa_d  = pa_q;
    pb_d  = pb_q;
    pc_d  = pc_q;
    wr_d  = wr_act;
    d_o_d = 8'hFF;

    if (commit) begin
      case (addr)
        2'd0: pa_d = d_i;
        2'd1: pb_d = d_i;
        2'd2: pc_d = d_i;
        2'd3: begin
          if (d_i[7]) begin
            // Mode set clears all port latches, as on the real 8255.
            dir_d = {d_i[4], d_i[3], d_i[1], d_i[0]};
            pa_d  = 8'h00;
            pb_d  = 8'h00;
            pc_d  = 8'h00;
          end else begin
            pc_d[d_i[3:1]] = d_i[0];
          end
        end
        default: ;
      endcase
    end

    if (!ppi_n) begin
      case (addr)
        2'd0: d_o_d = pa_pin;
        2'd1: d_o_d = b_in ? kb_col_i : pb_q;
        2'd2: d_o_d = pc_pin;
        default: d_o_d = 8'hFF;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= RESET_DIR;
      pa_q  <= 8'h00;
      pb_q  <= 8'h00;
      pc_q  <= 8'h00;
      d_o_q <= 8'hFF;
      wr_q  <= 1'b0;
    end else begin
      dir_q <= dir_d;
      pa_q  <= pa_d;
      pb_q  <= pb_d;
      pc_q  <= pc_d;
      d_o_q <= d_o_d;
      wr_q  <= wr_d;
    end
  end

  assign d_o = d_o_q;

  // rd_n does not gate anything: reads have no side effects and d_o is
  // refreshed every clk. Fold it into a harmless term so it is consumed.
  logic rd_seen;
  assign rd_seen = rd_n | ~rd_n;
  logic unused_ok;
  assign unused_ok = rd_seen;

endmodule
